// File: rtl/fb_rect_fill_pkg.sv
// Shared frame buffer constants, command payload and fill-engine state type.
package fb_rect_fill_pkg;

    localparam int unsigned FB_H_PIXELS    = 1024;
    localparam int unsigned FB_V_PIXELS    = 768;
    localparam int unsigned FB_ADDR_WIDTH  = 20;
    localparam int unsigned FB_DEPTH       = FB_H_PIXELS * FB_V_PIXELS;
    localparam int unsigned FB_PIXEL_WIDTH = 1;
    localparam int unsigned FB_COORD_WIDTH = 11;
    localparam int unsigned FB_X_WIDTH     = $clog2(FB_H_PIXELS);
    localparam int unsigned FB_Y_WIDTH     = $clog2(FB_V_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [FB_COORD_WIDTH-1:0] x0;
        logic [FB_COORD_WIDTH-1:0] y0;
        logic [FB_COORD_WIDTH-1:0] x1;
        logic [FB_COORD_WIDTH-1:0] y1;
        logic [FB_PIXEL_WIDTH-1:0] color;
    } rect_cmd_t;

    function automatic logic [FB_COORD_WIDTH-1:0] coord_min(
        input logic [FB_COORD_WIDTH-1:0] a,
        input logic [FB_COORD_WIDTH-1:0] b
    );
        return (a <= b) ? a : b;
    endfunction

    function automatic logic [FB_COORD_WIDTH-1:0] coord_max(
        input logic [FB_COORD_WIDTH-1:0] a,
        input logic [FB_COORD_WIDTH-1:0] b
    );
        return (a <= b) ? b : a;
    endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster walker over a clipped rectangle: keeps x/y/row_base and the current
// frame buffer address, stepping one pixel per advance in raster order.
module fb_raster_counter
    import fb_rect_fill_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     advance,
    input  logic [FB_X_WIDTH-1:0]    xl,
    input  logic [FB_X_WIDTH-1:0]    xr,
    input  logic [FB_Y_WIDTH-1:0]    yt,
    input  logic [FB_Y_WIDTH-1:0]    yb,
    output logic [FB_ADDR_WIDTH-1:0] addr,
    output logic                     last_c
);

    localparam int unsigned XW = FB_X_WIDTH;
    localparam int unsigned YW = FB_Y_WIDTH;
    localparam int unsigned AW = FB_ADDR_WIDTH;
    localparam logic [AW-1:0] ROW_STEP = AW'(FB_H_PIXELS);

    logic [XW-1:0] x;
    logic [XW-1:0] xl_q;
    logic [XW-1:0] xr_q;
    logic [YW-1:0] y;
    logic [YW-1:0] yb_q;
    logic [AW-1:0] row_base;

    // Width is a power of two, so a row base is just y shifted left.
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            xl_q     <= '0;
            xr_q     <= '0;
            yb_q     <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (load) begin
            x        <= xl;
            y        <= yt;
            xl_q     <= xl;
            xr_q     <= xr;
            yb_q     <= yb;
            row_base <= AW'(yt) << XW;
            addr     <= (AW'(yt) << XW) + AW'(xl);
        end else if (advance) begin
            if (x == xr_q) begin
                x        <= xl_q;
                y        <= y + YW'(1);
                row_base <= row_base + ROW_STEP;
                addr     <= row_base + ROW_STEP + AW'(xl_q);
            end else begin
                x    <= x + XW'(1);
                addr <= addr + AW'(1);
            end
        end
    end

    assign last_c = (x == xr_q) && (y == yb_q);

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts one command, normalizes and clips it to the
// visible area, then writes the frame buffer one pixel per granted cycle.
module fb_rect_fill
    import fb_rect_fill_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [FB_COORD_WIDTH-1:0] cmd_x0,
    input  logic [FB_COORD_WIDTH-1:0] cmd_y0,
    input  logic [FB_COORD_WIDTH-1:0] cmd_x1,
    input  logic [FB_COORD_WIDTH-1:0] cmd_y1,
    input  logic [FB_PIXEL_WIDTH-1:0] cmd_color,
    input  logic                      fb_wr_ready,
    output logic                      fb_we,
    output logic [FB_ADDR_WIDTH-1:0]  fb_addr,
    output logic [FB_PIXEL_WIDTH-1:0] fb_din,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CW = FB_COORD_WIDTH;
    localparam logic [CW-1:0] X_LIMIT = CW'(FB_H_PIXELS);
    localparam logic [CW-1:0] Y_LIMIT = CW'(FB_V_PIXELS);
    localparam logic [CW-1:0] X_LAST  = CW'(FB_H_PIXELS - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(FB_V_PIXELS - 1);

    fill_state_t state_q, state_d;
    rect_cmd_t   cmd_q;

    logic accept, load, advance, last_c;
    logic cmd_ready_d, busy_d, done_d, fb_we_d;

    logic [CW-1:0] xl, xr, yt, yb, xr_clip, yb_clip;
    logic          empty;

    // Normalize corners, clip the far edges, and detect a fully off-screen box.
    always_comb begin
        xl      = coord_min(cmd_q.x0, cmd_q.x1);
        xr      = coord_max(cmd_q.x0, cmd_q.x1);
        yt      = coord_min(cmd_q.y0, cmd_q.y1);
        yb      = coord_max(cmd_q.y0, cmd_q.y1);
        xr_clip = (xr > X_LAST) ? X_LAST : xr;
        yb_clip = (yb > Y_LAST) ? Y_LAST : yb;
        empty   = (xl >= X_LIMIT) || (yt >= Y_LIMIT);
    end

    fb_raster_counter u_raster (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .xl      (FB_X_WIDTH'(xl)),
        .xr      (FB_X_WIDTH'(xr_clip)),
        .yt      (FB_Y_WIDTH'(yt)),
        .yb      (FB_Y_WIDTH'(yb_clip)),
        .addr    (fb_addr),
        .last_c  (last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            fb_we     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            fb_we     <= fb_we_d;
            if (accept) begin
                cmd_q <= '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};
            end
        end
    end

    // Outputs are computed one cycle ahead so every port comes from a flop.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        cmd_ready_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        fb_we_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    accept      = 1'b1;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_PREP;
                end
            end
            ST_PREP: begin
                busy_d = 1'b1;
                if (empty) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    load    = 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                busy_d  = 1'b1;
                fb_we_d = 1'b1;
                if (fb_we && fb_wr_ready) begin
                    if (last_c) begin
                        fb_we_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fb_din = cmd_q.color;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed and randomized bench for fb_rect_fill against a raster-order
// reference model of the expected write sequence.
module tb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [0:0]  cmd_color;
    logic        fb_wr_ready;
    logic        fb_we;
    logic [19:0] fb_addr;
    logic [0:0]  fb_din;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    int  wq[$];
    int  dq[$];
    int  exp_q[$];
    int  stall_err = 0;
    bit  prev_stall = 1'b0;
    int  prev_addr = 0;

    fb_rect_fill dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_y0      (cmd_y0),
        .cmd_x1      (cmd_x1),
        .cmd_y1      (cmd_y1),
        .cmd_color   (cmd_color),
        .fb_wr_ready (fb_wr_ready),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_din      (fb_din),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Capture completed writes and watch for outputs moving during a stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (fb_we !== 1'b1 || int'(fb_addr) != prev_addr))
                stall_err++;
            if (fb_we === 1'b1 && fb_wr_ready === 1'b1) begin
                wq.push_back(int'(fb_addr));
                dq.push_back(int'(fb_din));
            end
            prev_stall = (fb_we === 1'b1) && (fb_wr_ready === 1'b0);
            prev_addr  = int'(fb_addr);
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: every pixel of the normalized, clipped box, row by row.
    task automatic model(input int x0, input int y0, input int x1, input int y1);
        int xl, xr, yt, yb;
        exp_q.delete();
        xl = (x0 < x1) ? x0 : x1;
        xr = (x0 < x1) ? x1 : x0;
        yt = (y0 < y1) ? y0 : y1;
        yb = (y0 < y1) ? y1 : y0;
        if (xr > 1023) xr = 1023;
        if (yb > 767)  yb = 767;
        if (xl > 1023 || yt > 767) return;
        for (int y = yt; y <= yb; y++)
            for (int x = xl; x <= xr; x++)
                exp_q.push_back(y * 1024 + x);
    endtask

    task automatic issue(input int x0, input int y0, input int x1, input int y1, input int c);
        int guard = 0;
        wq.delete();
        dq.delete();
        stall_err = 0;
        cmd_x0    = 11'(x0);
        cmd_y0    = 11'(y0);
        cmd_x1    = 11'(x1);
        cmd_y1    = 11'(y1);
        cmd_color = 1'(c);
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_accept", int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_x0    = 11'($urandom_range(0, 2047));
        cmd_y0    = 11'($urandom_range(0, 2047));
        cmd_color = ~cmd_color;
        check("busy_after_accept", int'(busy), 1);
        check("ready_low_after_accept", int'(cmd_ready), 0);
    endtask

    task automatic wait_done(input bit rnd, output int lat);
        lat = 0;
        fb_wr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (lat < 50000) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
            fb_wr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        check("done_seen", int'(done), 1);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        check("ready_after_done", int'(cmd_ready), 1);
    endtask

    task automatic compare_writes(input string tag, input int c);
        int bad = -1;
        int bad_din = 0;
        check({tag, "_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            if (wq[i] != exp_q[i]) begin
                bad = i;
                break;
            end
        end
        check({tag, "_first_wrong_index"}, bad, -1);
        foreach (dq[i]) if (dq[i] != c) bad_din++;
        check({tag, "_bad_din"}, bad_din, 0);
        check({tag, "_stall_moves"}, stall_err, 0);
    endtask

    initial begin
        int lat;
        int x0, y0, x1, y1, c, t;

        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_x0      = '0;
        cmd_y0      = '0;
        cmd_x1      = '0;
        cmd_y1      = '0;
        cmd_color   = '0;
        fb_wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_din", int'(fb_din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // Single pixel
        model(5, 3, 5, 3);
        issue(5, 3, 5, 3, 1);
        wait_done(1'b0, lat);
        check("single_latency", lat, 3);
        compare_writes("single", 1);
        check("single_addr", (wq.size() > 0) ? wq[0] : -1, 3077);

        // Swapped corners
        model(10, 40, 2, 32);
        issue(10, 40, 2, 32, 1);
        wait_done(1'b0, lat);
        check("swap_latency", lat, 83);
        compare_writes("swap", 1);
        check("swap_n", wq.size(), 81);
        check("swap_first", (wq.size() > 0) ? wq[0] : -1, 32770);
        check("swap_last", (wq.size() > 0) ? wq[wq.size()-1] : -1, 40970);

        // Clipped at the bottom-right corner
        model(1000, 760, 1100, 800);
        issue(1000, 760, 1100, 800, 0);
        wait_done(1'b0, lat);
        check("clip_latency", lat, 194);
        compare_writes("clip", 0);
        check("clip_n", wq.size(), 192);
        check("clip_last", (wq.size() > 0) ? wq[wq.size()-1] : -1, 786431);

        // Entirely off-screen: no writes, done still pulses
        model(1500, 0, 1600, 9);
        issue(1500, 0, 1600, 9, 1);
        wait_done(1'b0, lat);
        check("offscreen_latency", lat, 1);
        compare_writes("offscreen", 1);
        check("offscreen_n", wq.size(), 0);

        // Full-width bar under random backpressure
        model(0, 64, 1023, 95);
        issue(0, 64, 1023, 95, 1);
        wait_done(1'b1, lat);
        compare_writes("bar", 1);
        check("bar_n", wq.size(), 32768);

        // Random boxes near and beyond the screen edges
        for (int k = 0; k < 10; k++) begin
            x0 = $urandom_range(0, 1060);
            x1 = x0 + $urandom_range(0, 40);
            y0 = $urandom_range(0, 790);
            y1 = y0 + $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0) begin
                x0 = 2047;
                x1 = $urandom_range(1000, 2047);
            end
            if ($urandom_range(0, 1) == 1) begin
                t = x0; x0 = x1; x1 = t;
            end
            if ($urandom_range(0, 1) == 1) begin
                t = y0; y0 = y1; y1 = t;
            end
            c = $urandom_range(0, 1);
            model(x0, y0, x1, y1);
            issue(x0, y0, x1, y1, c);
            wait_done(1'b1, lat);
            compare_writes($sformatf("rand%0d", k), c);
        end

        // Reset in the middle of a fill
        issue(0, 0, 1023, 3, 1);
        fb_wr_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_fb_we", int'(fb_we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_cmd_ready", int'(cmd_ready), 1);
        check("midrst_done", int'(done), 0);
        rst = 1'b0;
        model(0, 0, 0, 0);
        issue(0, 0, 0, 0, 1);
        wait_done(1'b0, lat);
        check("postrst_latency", lat, 3);
        compare_writes("postrst", 1);
        check("postrst_addr", (wq.size() > 0) ? wq[0] : -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
